spi_slave_bus: RTL
==================

# spi_slave_bus

SPI mode-0 slave front end that turns raw SPI pin activity into the byte-wide register bus (`addr`, `data`, `first`, `strobe`) consumed by the `spi_reg` instances. It oversamples SCK/CS/MOSI in the system clock domain. The first byte of each chip-select frame becomes the address. Every following byte is presented as one strobed data byte. It also shifts a caller-supplied readback byte out on MISO for every byte slot after the address.

## Interface
- `SYNC_STAGES`, 2, synchronizer depth on SCK/CS_N/MOSI; legal values ≥ 2.
- `clk` input 1: system clock; f_clk ≥ 8·f_sck.
- `rst_n` input 1: asynchronous, active-low reset.
- `spi_sck` input 1: SPI clock, idles low (mode 0).
- `spi_cs_n` input 1: chip select, active low.
- `spi_mosi` input 1: master data, sampled on SCK rise, MSB first.
- `spi_miso` output 1: slave data, changes on SCK fall, MSB first.
- `spi_miso_oe` output 1: MISO output enable; high while the synchronized CS is active.
- `addr` output 8: address byte of the current or last frame.
- `data` output 8: last completed data byte.
- `first` output 1: qualifies `strobe`; high for the first data byte of a frame.
- `strobe` output 1: one-cycle pulse; one data byte is valid on `data`.
- `rd_data` input 8: readback byte; sampled when `rd_stb` is high.
- `rd_stb` output 1: one-cycle pulse; `rd_data` was latched this cycle.

## Operation
- Synchronizers: SCK, CS_N and MOSI each pass through `SYNC_STAGES` flops, then one delay flop on SCK for edge detect.
  - Reset levels: SCK 0, CS_N 1, MOSI 0.
  - rise = sck_s & ~sck_d; fall = ~sck_s & sck_d.
- State machine:
  - IDLE: synchronized CS_N high. Bit counter = 0. Edges are ignored. CS_N low → ADDR.
  - ADDR: on each rise, shift MOSI into an 8-bit shift register (LSB in) and increment the 3-bit counter. On the 8th rise:
    - `addr` ← byte.
    - `first_pending` ← 1.
    - Load the MISO shift register from `rd_data`; pulse `rd_stb`.
    - Go to DATA.
  - DATA: shift as in ADDR. On the 8th rise:
    - `data` ← byte; pulse `strobe`.
    - `first` ← `first_pending`; then `first_pending` ← 0.
    - Reload the MISO shift register from `rd_data`; pulse `rd_stb`.
    - Counter wraps to 0; stay in DATA.
  - CS_N high, synchronized, in any state → IDLE in the same cycle. Partial byte is discarded, counter cleared, no `strobe`, no `rd_stb`.
- MISO:
  - `spi_miso` = MSB of the MISO shift register.
  - On each fall in DATA, shift left with 0 fill.
  - During ADDR and IDLE the register is 0.
  - `spi_miso_oe` = ~cs_n_s.
- Priority: if CS_N deassert and a SCK rise are detected in the same cycle, the deassert wins and the edge is ignored.
- An address-only frame updates `addr`, pulses `rd_stb` once and never pulses `strobe`.
- `addr` and `data` hold their values across frames until overwritten; `first` holds until the next `strobe`.
- Reset values: `addr` 0x00, `data` 0x00, `first` 0, `strobe` 0, `rd_stb` 0, `spi_miso` 0, `spi_miso_oe` 0. State is IDLE; counter, shift registers and `first_pending` are 0.
- `rst_n` low mid-frame clears everything immediately. After release, a frame already in progress stays ignored until CS_N is seen high, then low again.

## Timing
- Byte completion latency: `strobe`, `data`, `first`, `rd_stb` and `addr` update on clk edge number `SYNC_STAGES`+1. Edge 1 is the first clk edge that captures the 8th raw SCK high.
- `strobe` and `rd_stb` are high for exactly one clk cycle per byte.
- `data` stays stable from `strobe` until the next `strobe`.
- `rd_data` must be valid in the `rd_stb` cycle; the upstream source may advance on that pulse.
- MISO bit 7 of a loaded byte is driven before the master's next SCK fall, guaranteed by f_clk ≥ 8·f_sck.
- Back-to-back bytes need no gap cycles; bytes are separated by at least 8 SCK periods.

## Test plan
- Write frame: CS low, send 0x12 then 0xA5, CS high → `addr`=0x12; one `strobe` with `data`=0xA5, `first`=1; `rd_stb` twice.
- Burst: addr 0x34, data 0x01 0x02 0x03 → three `strobe`s, `data` 0x01/0x02/0x03, `first` 1/0/0, `addr` stable at 0x34.
- Abort: addr 0x20, then 5 bits, then CS high → no `strobe`. Next frame, addr 0x21 + 0x7E → one `strobe`, `data`=0x7E, `first`=1, `addr`=0x21.
- Readback: `rd_data`=0xC3 at the first `rd_stb` → MISO sampled on the next 8 SCK rises reads 1,1,0,0,0,0,1,1; MISO=0 during the address byte; `spi_miso_oe` follows CS.
- Reset mid-byte: `rst_n` low after 4 data bits → all outputs 0 immediately. New frame addr 0x55 + 0xAA → `strobe`, `data`=0xAA, `first`=1.
- Latency: measure `strobe` at exactly `SYNC_STAGES`+1 clk edges after the 8th SCK rise is captured, for `SYNC_STAGES`=2 and 3; an address-only frame gives zero `strobe`s.

Source files
------------

// File: rtl/spi_slave_bus.sv
// SPI mode-0 slave front end. Oversamples SCK/CS_N/MOSI in the clk domain and
// turns each chip-select frame into an address byte followed by strobed data bytes.
module spi_slave_bus #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] addr,
  output logic [7:0] data,
  output logic       first,
  output logic       strobe,
  input  logic [7:0] rd_data,
  output logic       rd_stb
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   sck_d_q;

  logic sck_s, cs_n_s, mosi_s, vld_s;
  logic rise, fall;

  // vld_q fills with ones after reset so that the reset value parked in the
  // CS_N synchronizer is never mistaken for a real deassert of the pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      vld_q       <= '0;
      sck_d_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value,
      // which is what makes this a shift chain rather than a single wire.
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      sck_d_q     <= sck_sync_q[SYNC_STAGES-1];
    end
  end

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_n_s = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign vld_s  = vld_q[SYNC_STAGES-1];
  assign rise   = sck_s & ~sck_d_q;
  assign fall   = ~sck_s & sck_d_q;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  miso_sr_q, miso_sr_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        first_q, first_d;
  logic        first_pending_q, first_pending_d;
  logic        strobe_q, strobe_d;
  logic        rd_stb_q, rd_stb_d;
  logic        armed_q, armed_d;
  logic [7:0]  byte_next;

  assign byte_next = {shift_q[6:0], mosi_s};

  always_comb begin
    // NOTE: every next-state signal gets a default before any branch, so no
    // path through this block can leave a value unassigned and infer a latch.
    state_d         = state_q;
    cnt_d           = cnt_q;
    shift_d         = shift_q;
    miso_sr_d       = miso_sr_q;
    addr_d          = addr_q;
    data_d          = data_q;
    first_d         = first_q;
    first_pending_d = first_pending_q;
    strobe_d        = 1'b0;
    rd_stb_d        = 1'b0;
    armed_d         = armed_q;

    if (cs_n_s) begin
      // Deassert beats any edge seen in the same cycle; a partial byte is dropped.
      state_d         = ST_IDLE;
      cnt_d           = 3'd0;
      shift_d         = 8'h00;
      miso_sr_d       = 8'h00;
      first_pending_d = 1'b0;
      armed_d         = armed_q | vld_s;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (armed_q) begin
            state_d = ST_ADDR;
          end
        end

        ST_ADDR: begin
          if (rise) begin
            shift_d = byte_next;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              addr_d          = byte_next;
              first_pending_d = 1'b1;
              miso_sr_d       = rd_data;
              rd_stb_d        = 1'b1;
              state_d         = ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (rise) begin
            shift_d = byte_next;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              data_d          = byte_next;
              strobe_d        = 1'b1;
              first_d         = first_pending_q;
              first_pending_d = 1'b0;
              miso_sr_d       = rd_data;
              rd_stb_d        = 1'b1;
            end
          end else if (fall && cnt_q != 3'd0) begin
            // The fall that closes a byte must not shift: the freshly loaded
            // bit 7 has to survive until the master's next rise.
            miso_sr_d = {miso_sr_q[6:0], 1'b0};
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= 3'd0;
      shift_q         <= 8'h00;
      miso_sr_q       <= 8'h00;
      addr_q          <= 8'h00;
      data_q          <= 8'h00;
      first_q         <= 1'b0;
      first_pending_q <= 1'b0;
      strobe_q        <= 1'b0;
      rd_stb_q        <= 1'b0;
      armed_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      shift_q         <= shift_d;
      miso_sr_q       <= miso_sr_d;
      addr_q          <= addr_d;
      data_q          <= data_d;
      first_q         <= first_d;
      first_pending_q <= first_pending_d;
      strobe_q        <= strobe_d;
      rd_stb_q        <= rd_stb_d;
      armed_q         <= armed_d;
    end
  end

  assign spi_miso    = miso_sr_q[7];
  assign spi_miso_oe = ~cs_n_s;
  assign addr        = addr_q;
  assign data        = data_q;
  assign first       = first_q;
  assign strobe      = strobe_q;
  assign rd_stb      = rd_stb_q;

endmodule
